// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding instruction-memory read at a time,
// a single-entry output register toward decode, and control-flow redirects.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [1:0]  pcsrc,
   input  logic [31:0] imm_data,
   input  logic [27:0] addr_data,
   input  logic [31:0] jr_addr,
   output logic        misalign_err,
   output logic [1:0]  state_dbg
);

   // Handshakes: a memory read completes on a cycle with imem_req & imem_ack
   // (ack is meaningless while req is low); an instruction is handed to decode
   // on a cycle with inst_valid & inst_ready, and nothing else retires it.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        misalign_q, misalign_d;
   logic        fetch_done, accept;
   logic [31:0] pc4, target;
   logic        unused_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (imem_ack) state_d = S_FULL;
         S_FULL:  if (inst_ready) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == S_FETCH);
      state_dbg = state_q;
   end

   assign imem_addr    = pc_q;
   assign inst_valid   = inst_valid_q;
   assign inst_data    = inst_data_q;
   assign inst_pc      = inst_pc_q;
   assign misalign_err = misalign_q;

   assign fetch_done  = imem_req & imem_ack;
   assign accept      = inst_valid_q & inst_ready;
   assign pc4         = inst_pc_q + 32'd4;
   assign unused_bits = ^{imm_data[31:30], addr_data[1:0]};

   // Redirect targets are always forced word aligned.
   always_comb begin
      target = pc4;
      unique case (pcsrc)
         2'b00: target = pc4;
         2'b01: target = pc4 + {imm_data[29:0], 2'b00};
         2'b10: target = {pc4[31:28], addr_data[27:2], 2'b00};
         2'b11: target = {jr_addr[31:2], 2'b00};
         default: target = pc4;
      endcase
   end

   always_comb begin
      pc_d         = pc_q;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      misalign_d   = misalign_q;
      if (fetch_done) begin
         inst_data_d  = imem_rdata;
         inst_pc_d    = pc_q;
         inst_valid_d = 1'b1;
         pc_d         = pc_q + 32'd4;
      end
      if (accept) begin
         inst_valid_d = 1'b0;
         if (redirect) begin
            pc_d = target;
            if (pcsrc == 2'b11 && jr_addr[1:0] != 2'b00) misalign_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         inst_data_q  <= 32'd0;
         inst_pc_q    <= 32'd0;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         misalign_q   <= misalign_d;
      end
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; SHALL be word aligned.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  word-aligned read address; bits [1:0] always 2'b00.
REQ-006 imem_ack  input  1  read data valid this cycle; SHALL be ignored while imem_req=0.
REQ-007 imem_rdata  input  32  read data, sampled when imem_req&imem_ack.
REQ-008 inst_valid  output  1  inst_data/inst_pc hold an undelivered instruction.
REQ-009 inst_data  output  32  instruction word for the decode stage.
REQ-010 inst_pc  output  32  address the instruction in inst_data was fetched from.
REQ-011 inst_ready  input  1  decode stage accepts; accept = inst_valid&inst_ready.
REQ-012 redirect  input  1  control-flow change for the instruction being accepted.
REQ-013 pcsrc  input  2  target select: 00 seq, 01 branch, 10 jump, 11 register jump.
REQ-014 imm_data  input  32  sign/zero-extended branch offset, in words.
REQ-015 addr_data  input  28  jump field already shifted left by 2.
REQ-016 jr_addr  input  32  register jump target.
REQ-017 misalign_err  output  1  sticky flag: register-jump target had nonzero bits [1:0].

Function
REQ-018 FSM states IDLE, FETCH, FULL; IDLE->FETCH unconditionally on the first clock after reset release.
REQ-019 FETCH: imem_req=1 and imem_addr=pc; both SHALL stay stable until imem_ack.
REQ-020 FETCH with imem_ack: inst_data<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, next state FULL.
REQ-021 FULL: imem_req=0; inst_data, inst_pc and inst_valid SHALL hold while inst_ready=0.
REQ-022 FULL with accept: inst_valid<=0, next state FETCH; the next imem_req SHALL assert in the cycle after accept.
REQ-023 Latency: with a 1-cycle ack memory and inst_ready tied high, one instruction every 2 cycles; the first inst_valid arrives 2 cycles after reset release.
REQ-024 redirect SHALL be honoured only on an accept cycle; at any other time it SHALL be ignored.
REQ-025 On accept with redirect=1, pc<=target, replacing the sequential pc; pc4 = inst_pc+4.
REQ-026 Targets: 00 -> pc4; 01 -> pc4 + {imm_data[29:0],2'b00}; 10 -> {pc4[31:28], addr_data}; 11 -> {jr_addr[31:2],2'b00}.
REQ-027 All pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, and a negative branch below 0 wraps.
REQ-028 pcsrc=11 with jr_addr[1:0]!=0 on a redirect accept SHALL set misalign_err; fetch continues at the aligned address.
REQ-029 misalign_err SHALL clear only on reset.
REQ-030 No instruction is in flight while in FULL, so a redirect SHALL NOT discard any memory response.

Reset
REQ-031 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0.
REQ-032 Reset during an outstanding request abandons it; a late imem_ack SHALL be ignored while imem_req=0.

Verification
REQ-033 Reset release, 1-cycle memory returning 32'h2001_0005 at address 0, inst_ready=1 -> imem_req cycle 1; inst_valid cycle 2 with inst_data=32'h2001_0005, inst_pc=0; next imem_addr=4.
REQ-034 Memory ack delayed 3 cycles, inst_ready held 0 for 4 cycles -> imem_addr stable throughout; inst_data held; no new imem_req until accept.
REQ-035 Accept at inst_pc=32'h0000_0010 with redirect=1, pcsrc=01, imm_data=32'hFFFF_FFFB -> next imem_addr=32'h0000_0000; pcsrc=10, addr_data=28'h0000_040 -> imem_addr=32'h0000_0040.
REQ-036 Accept with redirect=1, pcsrc=11, jr_addr=32'h0000_1003 -> imem_addr=32'h0000_1000; misalign_err=1 and stays 1 until rst_n=0.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second fetch at 32'h0000_0000; redirect asserted while inst_valid=0 -> ignored.
REQ-038 rst_n pulsed low during FETCH, then ack arrives -> outputs at reset values; the ack is ignored; fetch restarts at RESET_PC.
